if_prefetch_unit: RTL

- Fetch-side front end of the pipelined RV32 core; sits directly upstream of the IF/ID pipeline register and replaces the bare PC + adder + instruction-memory path.
- Owns the fetch PC and issues sequential word fetches to a variable-latency instruction memory using a req/gnt/rvalid protocol.
- Buffers returned instructions in a small in-order prefetch queue and presents them to IF/ID with a valid/ready handshake.
- Accepts taken-branch and jalr redirects from EX/MEM, flushing the queue and discarding stale in-flight responses.

---
 rtl/core_pkg.sv | 16 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/if_prefetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core front end.
// Provides the datapath width, the default reset PC, the fetch entry
// layout used by the prefetch queue, and the canonical NOP encoding
// (addi x0, x0, 0).
package core_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0]     INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_data   write one entry at the tail
//   pop               remove the head entry
//   flush             discard all entries (wins over push/pop)
//   head_data         oldest entry, valid whenever count != 0
//   count             number of stored entries (0..DEPTH)
// The owner guarantees it never pushes into a full FIFO without a
// simultaneous pop and never pops an empty one.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; count alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= push_data;
    end

    assign head_data = mem[head];

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch-side front end: owns the fetch PC, issues sequential word fetches
// over a req/gnt/rvalid instruction memory interface, buffers returned
// instructions in order and hands them to IF/ID with valid/ready.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   redirect_valid, redirect_pc    taken branch / jalr target from EX/MEM
//   imem_req, imem_addr            fetch request and word-aligned address
//   imem_gnt                       request accepted this cycle
//   imem_rvalid, imem_rdata        in-order fetch response
//   if_valid, if_pc, if_inst       queue head presented to IF/ID
//   if_ready                       IF/ID takes the head this cycle
module if_prefetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    input  logic            if_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   fetch_pc;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     live;
    logic [CW-1:0]     q_count;
    logic [CW+1:0]     in_use;
    logic              credit;
    logic              grant;
    logic              rsp_drop;
    logic              rsp_keep;
    logic              pop;
    logic [XLEN-1:0]   pc_head;
    logic [2*XLEN-1:0] q_head;

    // Every fetch that is queued, expected back, or still to be thrown
    // away holds a slot, so a granted response always finds queue space.
    assign in_use   = (CW+2)'(q_count) + (CW+2)'(live) + (CW+2)'(discard);
    assign credit   = in_use < (CW+2)'(DEPTH);

    // Gated by rst so the request is low for the whole reset period.
    assign imem_req  = rst & credit & ~redirect_valid;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;

    // Stale responses are retired first; a response with nothing
    // outstanding is a protocol error and matches neither term.
    assign rsp_drop = imem_rvalid & (discard != '0);
    assign rsp_keep = imem_rvalid & (discard == '0) & (live != '0);

    assign if_valid = (q_count != '0);
    assign pop      = if_valid & if_ready & ~redirect_valid;
    assign if_pc    = if_valid ? q_head[2*XLEN-1:XLEN] : '0;
    assign if_inst  = if_valid ? q_head[XLEN-1:0]      : '0;

    // The PC tag FIFO's occupancy is the live in-flight count.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (fetch_pc),
        .pop       (rsp_keep & ~redirect_valid),
        .flush     (redirect_valid),
        .head_data (pc_head),
        .count     (live)
    );

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep & ~redirect_valid),
        .push_data ({pc_head, imem_rdata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (q_head),
        .count     (q_count)
    );

    // On a redirect every live fetch becomes one to discard, minus the
    // one whose response is arriving (and being dropped) right now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            discard  <= discard + live - CW'(rsp_drop | rsp_keep);
        end else begin
            if (grant)    fetch_pc <= fetch_pc + XLEN'(4);
            if (rsp_drop) discard  <= discard - CW'(1);
        end
    end

endmodule
